rad4_div: RTL and testbench
===========================

Name: rad4_div

Overview:
- Iterative unsigned radix-4 divider; the inverse of the team's radix-4 multiplier.
- Retires 2 quotient bits per cycle using two cascaded restoring subtract stages.
- Takes a 2*DIGITS-bit dividend and divisor and produces quotient and remainder.
- Sits beside the multiplier in the arithmetic datapath and uses a start/done handshake.

Parameters:
- DIGITS, 256: radix-4 digit count. Operand width W = 2*DIGITS; iteration count = DIGITS.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  W  dividend, sampled with start.
- divisor  input  W  divisor, sampled with start.
- busy  output  1  high while an operation is in progress (RUN or DONE state).
- done  output  1  single-cycle pulse; results valid from this cycle.
- quotient  output  W  registered quotient.
- remainder  output  W  registered remainder.
- div_by_zero  output  1  registered flag for the last operation; updated with done.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal partial remainder, quotient shift register and counter cleared.
- States:
  - IDLE: on start=1, latch operands.
    - If divisor==0, go to DONE.
    - Otherwise load partial remainder R=0, quotient shift Q=dividend, count=DIGITS-1, and go to RUN.
    - start=0 keeps IDLE.
  - RUN, stage 1: R1 = {R,Q[W-1]}, minus divisor if R1>=divisor; the bit shifted into Q is the comparison result.
  - RUN, stage 2: repeat stage 1 on (R1, Q shifted once).
  - RUN, width: R is held W+1 bits wide internally so the shifted compare never overflows.
  - RUN, exit: when count==0 (last iteration), go to DONE; otherwise count-1.
  - DONE: done=1 for exactly this cycle; quotient/remainder/div_by_zero registers loaded on the transition into DONE. Next state is always IDLE.
- Latency:
  - start sampled at edge t → done high in cycle t+DIGITS+1.
  - Divide-by-zero → done high in cycle t+1.
  - No back-to-back overlap: a new start is accepted in IDLE the cycle after DONE.
- Divide by zero: quotient = all ones, remainder = dividend, div_by_zero=1. Any nonzero divisor clears div_by_zero at its done.
- Output hold: quotient/remainder/div_by_zero hold their values from done until the next done or reset.
- start while busy: ignored; no effect on the in-flight operation or operand latches.
- reset mid-operation: synchronous abort to the reset state above; no done pulse; prior results are lost (cleared to 0).
- Simultaneous reset and start: reset wins; start is dropped.
- Boundaries:
  - dividend < divisor → q=0, r=dividend.
  - divisor=1 → q=dividend, r=0.
  - dividend=divisor → q=1, r=0.
  - All-ones operands are handled without overflow (W+1-bit R).

Optional Feature:
- Macro: RAD4_DIV_SIGNED_EN.
- Defined: operands are two's complement.
  - On accept, latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend); iterate on magnitudes.
  - On the transition into DONE, negate the quotient if sign_q and the remainder if sign_r (truncating division). Latency is unchanged.
  - Most-negative / -1 → quotient = most-negative (wraps), remainder=0.
  - Divide by zero → quotient = all ones (-1), remainder = dividend.
- Undefined: purely unsigned; no sign logic synthesized.

Test Plan (bench at DIGITS=4, W=8):
- Unsigned divide: start with dividend=200, divisor=7 → done exactly 5 cycles after the start edge; q=28, r=4, div_by_zero=0, busy high throughout.
- Small dividend and unity divisor: 7/200 → q=0, r=7. Then 255/1 → q=255, r=0. Then 255/255 → q=1, r=0.
- Divide by zero: 93/0 → done at t+1; q=255, r=93, div_by_zero=1. Following 10/3 → q=3, r=1, div_by_zero=0.
- start while busy: start 200/7, then pulse start with 50/5 at cycle t+2 → single done with q=28, r=4. The second request is not executed.
- Reset mid-operation: reset at t+3 of 200/7 → no done; outputs 0, busy 0. A new 100/9 → q=11, r=1 at normal latency.
- Signed, with RAD4_DIV_SIGNED_EN: -100/7 → q=0xF2 (-14), r=0xFE (-2). Then -128/-1 → q=0x80, r=0.

Source files
------------

// File: rtl/rad4_div_if.sv
// Start/done bus of the radix-4 divider: operands in, registered results out.
// The master drives the request side and the slave (rad4_div) drives the results.
interface rad4_div_if #(
  parameter int W = 512
);
  // Handshake: the divider samples start, dividend and divisor together on any
  // clock edge where it is idle (busy=0). It holds busy from that edge until the
  // done cycle ends. done lasts exactly one cycle. quotient, remainder and
  // div_by_zero are valid from that cycle and keep their values until the next
  // done or reset. A start seen while busy=1 is dropped; the divider does not queue it.
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, dbg_state
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, dbg_state
  );
endinterface

// File: rtl/rad4_div.sv
// Iterative radix-4 restoring divider: two cascaded subtract stages retire two quotient bits per cycle.
// Defining RAD4_DIV_SIGNED_EN selects two's complement operands with truncating division.
module rad4_div #(
  parameter int DIGITS = 256
) (
  input  logic      clk,
  input  logic      reset,
  rad4_div_if.slave bus
);
  localparam int W  = 2 * DIGITS;
  localparam int RW = W + 1;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W:0]    r_q;
  logic [W-1:0]  q_q;
  logic [W-1:0]  d_q;
  logic [CW-1:0] cnt_q;
  logic          accept;
  logic          zero_div;
  logic          finish;

  logic [W:0]    r1, r2;
  logic          qb1, qb2;
  logic [W-1:0]  q_nx;
  logic [W-1:0]  dvd_mag, dvs_mag;
  logic [W-1:0]  quo_fin, rem_fin;

`ifdef RAD4_DIV_SIGNED_EN
  logic sign_q, sign_r;
`endif

  // One restoring step. The shifted value is W+2 bits wide, so all-ones operands cannot overflow the compare.
  function automatic logic [W:0] rstep(input logic [W:0] r, input logic b,
                                       input logic [W-1:0] d, output logic qb);
    logic [W+1:0] sh;
    logic [W+1:0] dx;
    sh = {r, b};
    dx = {2'b00, d};
    qb = (sh >= dx);
    return qb ? RW'(sh - dx) : sh[W:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    zero_div = (bus.divisor == '0);
    finish   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = zero_div ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    r1   = rstep(r_q, q_q[W-1], d_q, qb1);
    r2   = rstep(r1, q_q[W-2], d_q, qb2);
    q_nx = W'({q_q, qb1, qb2});
  end

`ifdef RAD4_DIV_SIGNED_EN
  always_comb begin
    dvd_mag = bus.dividend[W-1] ? -bus.dividend : bus.dividend;
    dvs_mag = bus.divisor[W-1]  ? -bus.divisor  : bus.divisor;
    quo_fin = sign_q ? -q_nx : q_nx;
    rem_fin = sign_r ? -r2[W-1:0] : r2[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else if (accept) begin
      sign_q <= bus.dividend[W-1] ^ bus.divisor[W-1];
      sign_r <= bus.dividend[W-1];
    end
  end
`else
  always_comb begin
    dvd_mag = bus.dividend;
    dvs_mag = bus.divisor;
    quo_fin = q_nx;
    rem_fin = r2[W-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q             <= '0;
      q_q             <= '0;
      d_q             <= '0;
      cnt_q           <= '0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        r_q   <= '0;
        q_q   <= dvd_mag;
        d_q   <= dvs_mag;
        cnt_q <= CW'(DIGITS - 1);
        if (zero_div) begin
          bus.quotient    <= '1;
          bus.remainder   <= bus.dividend;
          bus.div_by_zero <= 1'b1;
        end
      end else if (state_q == RUN) begin
        r_q <= r2;
        q_q <= q_nx;
        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        if (finish) begin
          bus.quotient    <= quo_fin;
          bus.remainder   <= rem_fin;
          bus.div_by_zero <= 1'b0;
        end
      end
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_rad4_div.sv
// Self-checking bench for rad4_div at DIGITS=4 (W=8): constant vector table, handshake corner cases,
// and random operands scored against a plain-arithmetic model. Also covers the RAD4_DIV_SIGNED_EN build.
module tb_rad4_div;
  localparam int DIGITS = 4;
  localparam int W      = 2 * DIGITS;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r[$];

  rad4_div_if #(.W(W)) bus ();

  rad4_div #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  vec_t tbl[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division; zero divisor gives all ones and the dividend back.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
`ifdef RAD4_DIV_SIGNED_EN
    int sa;
    int sb;
`endif
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
`ifdef RAD4_DIV_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
`else
      q  = a / b;
      r  = a % b;
`endif
      z = 1'b0;
    end
  endfunction

  // Issues one request, waits for done (bounded), returns results, done-cycle number and busy dropouts.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                        output int lat, output int busy_lo);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat       = 1;
    busy_lo   = 0;
    while (!bus.done && lat < 40) begin
      if (!bus.busy) busy_lo++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.busy) busy_lo++;
    q = bus.quotient;
    r = bus.remainder;
    z = bus.div_by_zero;
    @(posedge clk);
    #1;
    check("done_single_pulse", {31'd0, bus.done}, 32'd0);
    check("busy_after_done", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] q, r, eq, er, a, b;
    logic         z, ez;
    int           lat, busy_lo, dones;

    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

`ifdef RAD4_DIV_SIGNED_EN
    tbl.push_back('{8'h9C, 8'd7,   8'hF2, 8'hFE, 1'b0});
    tbl.push_back('{8'h80, 8'hFF,  8'h80, 8'h00, 1'b0});
    tbl.push_back('{8'd7,  8'hFE,  8'hFD, 8'h01, 1'b0});
    tbl.push_back('{8'hF9, 8'd2,   8'hFD, 8'hFF, 1'b0});
    tbl.push_back('{8'd93, 8'd0,   8'hFF, 8'd93, 1'b1});
    tbl.push_back('{8'd10, 8'd3,   8'd3,  8'd1,  1'b0});
`else
    tbl.push_back('{8'd200, 8'd7,   8'd28,  8'd4,  1'b0});
    tbl.push_back('{8'd7,   8'd200, 8'd0,   8'd7,  1'b0});
    tbl.push_back('{8'd255, 8'd1,   8'd255, 8'd0,  1'b0});
    tbl.push_back('{8'd255, 8'd255, 8'd1,   8'd0,  1'b0});
    tbl.push_back('{8'd93,  8'd0,   8'd255, 8'd93, 1'b1});
    tbl.push_back('{8'd10,  8'd3,   8'd3,   8'd1,  1'b0});
`endif

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_quotient", 32'(bus.quotient), 32'd0);
    check("reset_remainder", 32'(bus.remainder), 32'd0);
    check("reset_dbz", {31'd0, bus.div_by_zero}, 32'd0);

    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, q, r, z, lat, busy_lo);
      check("tbl_quotient", 32'(q), 32'(tbl[i].q));
      check("tbl_remainder", 32'(r), 32'(tbl[i].r));
      check("tbl_dbz", {31'd0, z}, {31'd0, tbl[i].z});
      check("tbl_latency", 32'(lat), (tbl[i].b == '0) ? 32'd1 : 32'(DIGITS + 1));
      check("tbl_busy_held", 32'(busy_lo), 32'd0);
    end

    // A second start while busy must be ignored: one done, first operands' result.
    model(8'd200, 8'd7, eq, er, ez);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 8'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dones     = 0;
    q         = '0;
    r         = '0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 2) begin
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 8'd5;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        dones++;
        if (dones == 1) begin
          q = bus.quotient;
          r = bus.remainder;
        end
      end
      @(posedge clk);
      #1;
    end
    check("busy_start_dones", 32'(dones), 32'd1);
    check("busy_start_quotient", 32'(q), 32'(eq));
    check("busy_start_remainder", 32'(r), 32'(er));

    // Reset sampled at edge t+3 aborts the operation and clears the results.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 8'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.done) dones++;
      @(posedge clk);
      #1;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_quotient", 32'(bus.quotient), 32'd0);
    check("abort_remainder", 32'(bus.remainder), 32'd0);
    check("abort_dbz", {31'd0, bus.div_by_zero}, 32'd0);

    model(8'd100, 8'd9, eq, er, ez);
    run_op(8'd100, 8'd9, q, r, z, lat, busy_lo);
    check("after_abort_quotient", 32'(q), 32'(eq));
    check("after_abort_remainder", 32'(r), 32'(er));
    check("after_abort_latency", 32'(lat), 32'(DIGITS + 1));

    // Reset and start on the same edge: start is dropped.
    @(negedge clk);
    reset        = 1'b1;
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 8'd7;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    bus.start = 1'b0;
    dones     = 0;
    lat       = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.done) dones++;
      if (bus.busy) lat++;
      @(posedge clk);
      #1;
    end
    check("reset_start_no_done", 32'(dones), 32'd0);
    check("reset_start_no_busy", 32'(lat), 32'd0);

    for (int n = 0; n < 40; n++) begin
      a = W'($urandom_range(0, 255));
      b = ($urandom_range(0, 6) == 0) ? '0 : W'($urandom_range(1, 255));
      model(a, b, eq, er, ez);
      exp_q.push_back(eq);
      exp_r.push_back(er);
      run_op(a, b, q, r, z, lat, busy_lo);
      check("rnd_quotient", 32'(q), 32'(exp_q.pop_front()));
      check("rnd_remainder", 32'(r), 32'(exp_r.pop_front()));
      check("rnd_dbz", {31'd0, z}, {31'd0, ez});
      check("rnd_latency", 32'(lat), (b == '0) ? 32'd1 : 32'(DIGITS + 1));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    check("scoreboard_empty", 32'(exp_q.size() + exp_r.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
